// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared types and constants for the UART memory loader
package loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_LEN_LO,
      ST_LEN_HI,
      ST_DATA,
      ST_CSUM
   } state_e;

   typedef enum logic [2:0] {
      U_IDLE,
      U_START,
      U_DATA,
      U_STOP,
      U_BREAK
   } uart_state_e;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   // Byte positions of the header fields within a frame.
   localparam int HDR_SYNC_OFS   = 0;
   localparam int HDR_SEL_OFS    = 1;
   localparam int HDR_LEN_LO_OFS = 2;
   localparam int HDR_LEN_HI_OFS = 3;

   // Bit positions of the two LEN bytes within the 16-bit word count.
   localparam int LEN_LO_SHIFT = 8 * (HDR_LEN_LO_OFS - HDR_LEN_LO_OFS);
   localparam int LEN_HI_SHIFT = 8 * (HDR_LEN_HI_OFS - HDR_LEN_LO_OFS);

   function automatic int calc_bpw(input int data_w);
      return data_w / 8;
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 8N1 UART receiver: synchroniser, bit timer, deserialiser
module uart_rx_core
   import loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        rx_i,
   input  logic [15:0] clks_per_bit,
   output logic        dv_o,
   output logic [7:0]  byte_o
);

   logic        rx_meta_q, rx_sync_q;
   uart_state_e state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  byte_q, byte_d;
   logic        dv_q, dv_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         state_q   <= U_IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         byte_q    <= '0;
         dv_q      <= 1'b0;
      end else begin
         rx_meta_q <= rx_i;
         rx_sync_q <= rx_meta_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         byte_q    <= byte_d;
         dv_q      <= dv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      byte_d  = byte_q;
      dv_d    = 1'b0;
      unique case (state_q)
         U_IDLE: begin
            cnt_d = '0;
            if (!rx_sync_q) state_d = U_START;
         end
         U_START: begin
            if (cnt_q == (clks_per_bit >> 1) - 16'd1) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = rx_sync_q ? U_IDLE : U_DATA;
            end
         end
         U_DATA: begin
            if (cnt_q == clks_per_bit - 16'd1) begin
               cnt_d   = '0;
               shift_d = {rx_sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = U_STOP;
            end
         end
         U_STOP: begin
            if (cnt_q == clks_per_bit - 16'd1) begin
               cnt_d = '0;
               if (rx_sync_q) begin
                  dv_d    = 1'b1;
                  byte_d  = shift_q;
                  state_d = U_IDLE;
               end else begin
                  state_d = U_BREAK;
               end
            end
         end
         U_BREAK: begin
            // Framing error: wait for the line to return high before hunting for a start bit.
            cnt_d = '0;
            if (rx_sync_q) state_d = U_IDLE;
         end
         default: state_d = U_IDLE;
      endcase
   end

   assign dv_o   = dv_q;
   assign byte_o = byte_q;

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - framed UART loader writing words into one of NUM_MEM memories
module uart_mem_loader
   import loader_pkg::*;
#(
   parameter int         DATA_W    = 32,
   parameter int         ADDR_W    = 12,
   parameter int         NUM_MEM   = 2,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               prog_i,
   input  logic               rx_i,
   input  logic [15:0]        clks_per_bit,
   output logic [NUM_MEM-1:0] we_o,
   output logic [ADDR_W-1:0]  addr_o,
   output logic [DATA_W-1:0]  wdata_o,
   output logic               reset_o,
   output logic               busy_o,
   output logic               err_o
);

   localparam int BPW    = calc_bpw(DATA_W);
   localparam int LANE_W = (BPW > 1) ? $clog2(BPW) : 1;

   logic       rx_dv;
   logic [7:0] rx_byte;

   uart_rx_core u_rx (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .rx_i         (rx_i),
      .clks_per_bit (clks_per_bit),
      .dv_o         (rx_dv),
      .byte_o       (rx_byte)
   );

   state_e             state_q, state_d;
   logic [7:0]         sel_q, sel_d;
   logic [15:0]        len_q, len_d;
   logic [15:0]        words_q, words_d;
   logic [LANE_W-1:0]  lane_q, lane_d;
   logic [DATA_W-1:0]  word_q, word_d;
   logic [7:0]         csum_q, csum_d;
   logic [ADDR_W-1:0]  waddr_q, waddr_d;
   logic               err_q, err_d;
   logic [NUM_MEM-1:0] we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic               reset_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         len_q   <= '0;
         words_q <= '0;
         lane_q  <= '0;
         word_q  <= '0;
         csum_q  <= '0;
         waddr_q <= '0;
         err_q   <= 1'b0;
         we_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         reset_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         len_q   <= len_d;
         words_q <= words_d;
         lane_q  <= lane_d;
         word_q  <= word_d;
         csum_q  <= csum_d;
         waddr_q <= waddr_d;
         err_q   <= err_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         reset_q <= prog_i | busy_o;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      len_d   = len_q;
      words_d = words_q;
      lane_d  = lane_q;
      word_d  = word_q;
      csum_d  = csum_q;
      waddr_d = waddr_q;
      err_d   = err_q;
      we_d    = '0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      // Leaving programming mode mid-frame wins over any byte arriving this cycle.
      if (state_q != ST_IDLE && !prog_i) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end else if (rx_dv) begin
         unique case (state_q)
            ST_IDLE: begin
               if (prog_i && rx_byte == SYNC_BYTE) begin
                  state_d = ST_SEL;
                  err_d   = 1'b0;
                  csum_d  = '0;
               end
            end
            ST_SEL: begin
               sel_d   = rx_byte;
               if (int'(rx_byte) >= NUM_MEM) err_d = 1'b1;
               state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
               len_d[LEN_LO_SHIFT +: 8] = rx_byte;
               state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
               len_d[LEN_HI_SHIFT +: 8] = rx_byte;
               waddr_d = '0;
               words_d = '0;
               lane_d  = '0;
               state_d = (len_d == 16'd0) ? ST_CSUM : ST_DATA;
            end
            ST_DATA: begin
               csum_d = csum_q ^ rx_byte;
               word_d[int'(lane_q)*8 +: 8] = rx_byte;
               if (lane_q == LANE_W'(BPW - 1)) begin
                  lane_d = '0;
                  for (int m = 0; m < NUM_MEM; m++) begin
                     if (int'(sel_q) == m) we_d[m] = 1'b1;
                  end
                  addr_d  = waddr_q;
                  wdata_d = word_d;
                  waddr_d = waddr_q + ADDR_W'(1);
                  words_d = words_q + 16'd1;
                  if (words_d == len_q) state_d = ST_CSUM;
               end else begin
                  lane_d = lane_q + LANE_W'(1);
               end
            end
            ST_CSUM: begin
               if (rx_byte != csum_q) err_d = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign we_o    = we_q;
   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign busy_o  = (state_q != ST_IDLE);
   assign err_o   = err_q;
   assign reset_o = reset_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - self-checking bench for uart_mem_loader
module tb_uart_mem_loader;

   localparam int CPB = 16;
   localparam int FB  = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        prog = 1'b0;
   logic        rx = 1'b1;
   logic [15:0] cpb = 16'(CPB);

   logic [1:0]  we, we2;
   logic [11:0] addr;
   logic [1:0]  addr2;
   logic [31:0] wdata, wdata2;
   logic        reset_o, reset2, busy, busy2, err, err2;

   uart_mem_loader dut (
      .clk_i(clk), .rst_ni(rst_n), .prog_i(prog), .rx_i(rx), .clks_per_bit(cpb),
      .we_o(we), .addr_o(addr), .wdata_o(wdata), .reset_o(reset_o), .busy_o(busy), .err_o(err)
   );

   uart_mem_loader #(.ADDR_W(2)) dut2 (
      .clk_i(clk), .rst_ni(rst_n), .prog_i(prog), .rx_i(rx), .clks_per_bit(cpb),
      .we_o(we2), .addr_o(addr2), .wdata_o(wdata2), .reset_o(reset2), .busy_o(busy2), .err_o(err2)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [1:0]  wr_we[$];
   logic [11:0] wr_addr[$];
   logic [31:0] wr_data[$];
   logic [1:0]  wr2_addr[$];
   logic [31:0] wr2_data[$];
   logic        watch_reset = 1'b0;
   logic        reset_drop = 1'b0;
   logic        multi_we = 1'b0;

   always @(negedge clk) begin
      if (we != 2'b00) begin
         wr_we.push_back(we);
         wr_addr.push_back(addr);
         wr_data.push_back(wdata);
      end
      if (we2 != 2'b00) begin
         wr2_addr.push_back(addr2);
         wr2_data.push_back(wdata2);
      end
      if ($countones(we) > 1) multi_we = 1'b1;
      if (watch_reset && (reset_o !== 1'b1 || reset2 !== 1'b1)) reset_drop = 1'b1;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_we.delete();
      wr_addr.delete();
      wr_data.delete();
      wr2_addr.delete();
      wr2_data.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic bad_stop);
      @(negedge clk);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = ~bad_stop;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   typedef struct {
      int              nbytes;
      logic [FB-1:0]   bytes;
      int              nwr;
      logic [1:0]      we;
      logic [5*12-1:0] addr;
      logic [5*32-1:0] data;
      logic            err;
   } vec_t;

   vec_t vec[6];
   logic [7:0] seq[$];

   initial begin
      vec[0] = '{13, FB'({8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                          8'h55, 8'h66, 8'h77, 8'h88, 8'h88}),
                 2, 2'b01, {12'd0, 12'd0, 12'd0, 12'd1, 12'd0},
                 {32'h0, 32'h0, 32'h0, 32'h88776655, 32'h44332211}, 1'b0};
      vec[1] = '{13, FB'({8'hA5, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                          8'h55, 8'h66, 8'h77, 8'h88, 8'hFF}),
                 2, 2'b01, {12'd0, 12'd0, 12'd0, 12'd1, 12'd0},
                 {32'h0, 32'h0, 32'h0, 32'h88776655, 32'h44332211}, 1'b1};
      vec[2] = '{9, FB'({8'hA5, 8'h05, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04}),
                 0, 2'b00, 60'd0, 160'd0, 1'b1};
      vec[3] = '{5, FB'({8'hA5, 8'h00, 8'h00, 8'h00, 8'h00}),
                 0, 2'b00, 60'd0, 160'd0, 1'b0};
      vec[4] = '{11, FB'({8'h00, 8'hFF, 8'hA5, 8'h01, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}),
                 1, 2'b10, 60'd0, {128'd0, 32'hEFBEADDE}, 1'b0};
      vec[5] = '{25, FB'({8'hA5, 8'h01, 8'h05, 8'h00,
                          8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                          8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
                          8'h11, 8'h12, 8'h13, 8'h14, 8'h14}),
                 5, 2'b10, {12'd4, 12'd3, 12'd2, 12'd1, 12'd0},
                 {32'h14131211, 32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201}, 1'b0};

      repeat (4) @(negedge clk);
      chk("rst_we", we, 2'b00);
      chk("rst_addr", addr, 12'd0);
      chk("rst_wdata", wdata, 32'd0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_reset_o", reset_o, 1'b0);

      rst_n = 1'b1;
      prog = 1'b1;
      repeat (4) @(negedge clk);
      chk("prog_reset_o", reset_o, 1'b1);

      watch_reset = 1'b1;
      for (int v = 0; v < 6; v++) begin
         clear_log();
         reset_drop = 1'b0;
         for (int i = 0; i < vec[v].nbytes; i++)
            send_byte(vec[v].bytes[(vec[v].nbytes - 1 - i) * 8 +: 8], 1'b0);
         chk($sformatf("v%0d_wr_count", v), wr_we.size(), vec[v].nwr);
         chk($sformatf("v%0d_wr2_count", v), wr2_addr.size(), vec[v].nwr);
         for (int i = 0; i < vec[v].nwr; i++) begin
            if (i < wr_we.size()) begin
               chk($sformatf("v%0d_wr%0d_we", v, i), wr_we[i], vec[v].we);
               chk($sformatf("v%0d_wr%0d_addr", v, i), wr_addr[i], vec[v].addr[i*12 +: 12]);
               chk($sformatf("v%0d_wr%0d_data", v, i), wr_data[i], vec[v].data[i*32 +: 32]);
            end
            if (i < wr2_addr.size()) begin
               chk($sformatf("v%0d_wr%0d_addr2", v, i), wr2_addr[i], vec[v].addr[i*12 +: 2]);
               chk($sformatf("v%0d_wr%0d_data2", v, i), wr2_data[i], vec[v].data[i*32 +: 32]);
            end
         end
         chk($sformatf("v%0d_err", v), err, vec[v].err);
         chk($sformatf("v%0d_err2", v), err2, vec[v].err);
         chk($sformatf("v%0d_busy", v), busy, 1'b0);
         chk($sformatf("v%0d_busy2", v), busy2, 1'b0);
         chk($sformatf("v%0d_reset_held", v), reset_drop, 1'b0);
         chk($sformatf("v%0d_onehot", v), multi_we, 1'b0);
      end
      watch_reset = 1'b0;

      // reset_o falls one cycle after prog_i when the loader is already idle
      @(negedge clk);
      prog = 1'b0;
      #1;
      chk("reset_o_before_edge", reset_o, 1'b1);
      @(negedge clk);
      chk("reset_o_after_prog_fall", reset_o, 1'b0);
      prog = 1'b1;
      repeat (3) @(negedge clk);

      // stop bit forced low on data byte 02
      clear_log();
      seq = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h00};
      foreach (seq[i]) send_byte(seq[i], (i == 5));
      chk("stop_wr_count", wr_we.size(), 1);
      if (wr_data.size() > 0) chk("stop_wr_data", wr_data[0], 32'h04040301);
      chk("stop_err", err, 1'b1);
      chk("stop_busy", busy, 1'b0);

      // new SYNC clears err, then abort mid-word
      clear_log();
      send_byte(8'hA5, 1'b0);
      chk("sync_clears_err", err, 1'b0);
      chk("sync_sets_busy", busy, 1'b1);
      seq = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
      foreach (seq[i]) send_byte(seq[i], 1'b0);
      prog = 1'b0;
      @(negedge clk);
      chk("abort_busy", busy, 1'b0);
      chk("abort_err", err, 1'b1);
      chk("abort_reset_o_hold", reset_o, 1'b1);
      @(negedge clk);
      chk("abort_reset_o_fall", reset_o, 1'b0);
      repeat (4 * CPB) @(negedge clk);
      chk("abort_no_write", wr_we.size(), 0);

      // asynchronous reset in the middle of a frame
      prog = 1'b1;
      repeat (3) @(negedge clk);
      send_byte(8'hA5, 1'b0);
      send_byte(8'h00, 1'b0);
      chk("pre_arst_busy", busy, 1'b1);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_we", we, 2'b00);
      chk("arst_addr", addr, 12'd0);
      chk("arst_wdata", wdata, 32'd0);
      chk("arst_busy", busy, 1'b0);
      chk("arst_err", err, 1'b0);
      chk("arst_reset_o", reset_o, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
